// File: rtl/param_register_file.sv
// Parametrised register file with per-register function control and a move/swap sequencer.
// Latency: reads are combinational (zero cycles); writes land on the rising edge; move 2 edges, swap 4 edges.
// Backpressure: while Busy is high, external FunSel writes and MvStart are ignored; reads stay live.
module param_register_file #(
   parameter int WIDTH  = 16,
   parameter int NREGS  = 8,
   parameter int NREAD  = 2,
   parameter int SELW   = $clog2(NREGS),
   parameter bit BYPASS = 1'b0
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic [WIDTH-1:0]       I,
   input  logic [2:0]             FunSel,
   input  logic [NREGS-1:0]       RegSel,
   input  logic [NREAD*SELW-1:0]  OutSel,
   output logic [NREAD*WIDTH-1:0] OutData,
   input  logic                   MvStart,
   input  logic                   MvSwap,
   input  logic [SELW-1:0]        MvSrc,
   input  logic [SELW-1:0]        MvDst,
   output logic                   Busy,
   output logic                   Done
);

   // Byte ops work on the low byte; narrower registers treat the whole register as that byte.
   localparam int               BW      = (WIDTH < 8) ? WIDTH : 8;
   localparam logic [WIDTH-1:0] LO_MASK = {WIDTH{1'b1}} >> (WIDTH - BW);
   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {IDLE, MOVE, SW1, SW2, SW3} state_t;

   state_t           state, state_nxt;
   logic [SELW-1:0]  src, dst;
   logic [WIDTH-1:0] tmp;
   logic [WIDTH-1:0] regs [NREGS];

   // Next value of one register for a given function code.
   function automatic logic [WIDTH-1:0] apply_fun(input logic [2:0] f,
                                                  input logic [WIDTH-1:0] r,
                                                  input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] lo;
      lo = d & LO_MASK;
      case (f)
         3'b000:  apply_fun = r - ONE;
         3'b001:  apply_fun = r + ONE;
         3'b010:  apply_fun = d;
         3'b011:  apply_fun = '0;
         3'b100:  apply_fun = lo;
         3'b101:  apply_fun = (r & ~LO_MASK) | lo;
         3'b110:  apply_fun = (WIDTH <= 8) ? lo : ((lo << 8) | (r & LO_MASK));
         default: apply_fun = d[BW-1] ? (lo | ~LO_MASK) : lo;
      endcase
   endfunction

   assign Busy = (state != IDLE);

   // Sequencer next state: start only from IDLE, then walk the fixed move or swap path.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (MvStart) state_nxt = MvSwap ? SW1 : MOVE;
         MOVE:    state_nxt = IDLE;
         SW1:     state_nxt = SW2;
         SW2:     state_nxt = SW3;
         SW3:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Sequencer state, latched indices and the completion pulse.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state <= IDLE;
         src   <= '0;
         dst   <= '0;
         Done  <= 1'b0;
      end else begin
         state <= state_nxt;
         Done  <= (state == MOVE) || (state == SW3);
         if (state == IDLE && MvStart) begin
            src <= MvSrc;
            dst <= MvDst;
         end
      end
   end

   // Register array: external functions in IDLE, sequencer transfers otherwise.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         tmp <= '0;
         for (int k = 0; k < NREGS; k++) regs[k] <= '0;
      end else begin
         case (state)
            IDLE: begin
               for (int k = 0; k < NREGS; k++)
                  if (!RegSel[k]) regs[k] <= apply_fun(FunSel, regs[k], I);
            end
            MOVE:    regs[dst] <= regs[src];
            SW1:     tmp <= regs[src];
            SW2:     regs[src] <= regs[dst];
            SW3:     regs[dst] <= tmp;
            default: tmp <= tmp;
         endcase
      end
   end

   // Read ports: direct array lookup, optionally forwarding a same-cycle full load.
   always_comb begin
      logic [SELW-1:0] sel;
      OutData = '0;
      sel     = '0;
      for (int p = 0; p < NREAD; p++) begin
         sel = OutSel[p*SELW +: SELW];
         if (BYPASS && Reset && !Busy && !RegSel[sel] && FunSel == 3'b010)
            OutData[p*WIDTH +: WIDTH] = I;
         else
            OutData[p*WIDTH +: WIDTH] = regs[sel];
      end
   end

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: table-driven function vectors plus hand-written sequencer sequences.
// Two instances share write/sequencer inputs: A (BYPASS=0, NREAD=2) and B (BYPASS=1, NREAD=3).
// Expected values are hand-derived constants queued as stimulus is driven.
module tb_param_register_file;

   logic        Clock;
   logic        Reset;
   logic [15:0] I;
   logic [2:0]  FunSel;
   logic [7:0]  RegSel;
   logic        MvStart, MvSwap;
   logic [2:0]  MvSrc, MvDst;
   logic [5:0]  OutSel_a;
   logic [31:0] OutData_a;
   logic        Busy_a, Done_a;
   logic [8:0]  OutSel_b;
   logic [47:0] OutData_b;
   logic        Busy_b, Done_b;

   int total  = 0;
   int passed = 0;

   param_register_file #(.WIDTH(16), .NREGS(8), .NREAD(2), .BYPASS(1'b0)) dut_a (
      .Clock(Clock), .Reset(Reset), .I(I), .FunSel(FunSel), .RegSel(RegSel),
      .OutSel(OutSel_a), .OutData(OutData_a), .MvStart(MvStart), .MvSwap(MvSwap),
      .MvSrc(MvSrc), .MvDst(MvDst), .Busy(Busy_a), .Done(Done_a));

   param_register_file #(.WIDTH(16), .NREGS(8), .NREAD(3), .BYPASS(1'b1)) dut_b (
      .Clock(Clock), .Reset(Reset), .I(I), .FunSel(FunSel), .RegSel(RegSel),
      .OutSel(OutSel_b), .OutData(OutData_b), .MvStart(MvStart), .MvSwap(MvSwap),
      .MvSrc(MvSrc), .MvDst(MvDst), .Busy(Busy_b), .Done(Done_b));

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      logic [7:0]  regsel;
      logic [2:0]  fun;
      logic [15:0] din;
      logic [2:0]  rd;
      logic [15:0] exp;
   } vec_t;

   typedef struct {
      logic [2:0]  rd;
      logic [15:0] exp;
      int          id;
   } sb_t;

   localparam int NV = 16;
   vec_t vecs [NV];
   sb_t  sbq [$];

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic read_a(input logic [2:0] idx, output logic [15:0] val);
      OutSel_a[2:0] = idx;
      #1;
      val = OutData_a[15:0];
   endtask

   task automatic write_regs(input logic [7:0] rs, input logic [2:0] f, input logic [15:0] d);
      RegSel = rs; FunSel = f; I = d;
      step();
      RegSel = 8'hFF;
   endtask

   // Counts cycles with Busy high, bounded so a stuck sequencer still ends the run.
   task automatic count_busy(output int n);
      int g;
      n = 0;
      g = 0;
      while (Busy_a && g < 20) begin
         n++;
         g++;
         step();
      end
      RegSel = 8'hFF;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [15:0] v;
      int          n;
      logic        done_seen;
      sb_t         e;

      vecs[0]  = '{8'hFE, 3'b010, 16'h1234, 3'd0, 16'h1234};
      vecs[1]  = '{8'hFF, 3'b010, 16'h5555, 3'd1, 16'h0000};
      vecs[2]  = '{8'hF7, 3'b010, 16'hFFFF, 3'd3, 16'hFFFF};
      vecs[3]  = '{8'hF7, 3'b001, 16'h0000, 3'd3, 16'h0000};
      vecs[4]  = '{8'hF7, 3'b000, 16'h0000, 3'd3, 16'hFFFF};
      vecs[5]  = '{8'hFD, 3'b010, 16'hABCD, 3'd1, 16'hABCD};
      vecs[6]  = '{8'hFD, 3'b101, 16'h0080, 3'd1, 16'hAB80};
      vecs[7]  = '{8'hFD, 3'b110, 16'h0080, 3'd1, 16'h8080};
      vecs[8]  = '{8'hFD, 3'b111, 16'h0080, 3'd1, 16'hFF80};
      vecs[9]  = '{8'hFD, 3'b100, 16'h12F3, 3'd1, 16'h00F3};
      vecs[10] = '{8'hFD, 3'b011, 16'h0000, 3'd1, 16'h0000};
      vecs[11] = '{8'hDB, 3'b010, 16'h00AA, 3'd2, 16'h00AA};
      vecs[12] = '{8'hFF, 3'b011, 16'h0000, 3'd5, 16'h00AA};
      vecs[13] = '{8'hDF, 3'b010, 16'h0055, 3'd5, 16'h0055};
      vecs[14] = '{8'hFF, 3'b000, 16'h0000, 3'd2, 16'h00AA};
      vecs[15] = '{8'hFF, 3'b000, 16'h0000, 3'd0, 16'h1234};

      Reset = 1'b0; I = '0; FunSel = 3'b011; RegSel = 8'hFF;
      MvStart = 1'b0; MvSwap = 1'b0; MvSrc = '0; MvDst = '0;
      OutSel_a = '0; OutSel_b = '0;
      #12;
      check("reset_busy", Busy_a, 1'b0);
      check("reset_done", Done_a, 1'b0);
      check("reset_out_a", OutData_a, 32'h0);
      check("reset_out_b", OutData_b, 48'h0);
      Reset = 1'b1;
      step();

      // Function table
      for (int k = 0; k < NV; k++) begin
         RegSel = vecs[k].regsel; FunSel = vecs[k].fun; I = vecs[k].din;
         sbq.push_back('{vecs[k].rd, vecs[k].exp, k});
         step();
         RegSel = 8'hFF;
         e = sbq.pop_front();
         OutSel_a = {3'd0, e.rd};
         OutSel_b = {3{e.rd}};
         #1;
         check($sformatf("vec%0d_a", e.id), OutData_a[15:0], e.exp);
         check($sformatf("vec%0d_b", e.id), OutData_b[47:32], e.exp);
      end

      // Move R2 -> R5 with a same-edge increment of R0, then a clear of R5 attempted while busy
      MvSrc = 3'd2; MvDst = 3'd5; MvSwap = 1'b0; MvStart = 1'b1;
      RegSel = 8'hFE; FunSel = 3'b001;
      step();
      MvStart = 1'b0; RegSel = 8'hDF; FunSel = 3'b011;
      check("move_busy", Busy_a, 1'b1);
      count_busy(n);
      check("move_busy_cycles", n, 1);
      check("move_done", Done_a, 1'b1);
      read_a(3'd5, v); check("move_r5", v, 16'h00AA);
      read_a(3'd2, v); check("move_r2", v, 16'h00AA);
      read_a(3'd0, v); check("start_edge_write_r0", v, 16'h1235);
      step();
      check("move_done_drop", Done_a, 1'b0);

      // Swap R2 <-> R5
      write_regs(8'hDF, 3'b010, 16'h0055);
      MvSwap = 1'b1; MvStart = 1'b1;
      step();
      MvStart = 1'b0;
      count_busy(n);
      check("swap_busy_cycles", n, 3);
      check("swap_done", Done_a, 1'b1);
      read_a(3'd2, v); check("swap_r2", v, 16'h0055);
      read_a(3'd5, v); check("swap_r5", v, 16'h00AA);
      step();
      check("swap_done_drop", Done_a, 1'b0);

      // Swap with Src == Dst, then a back-to-back move accepted in the Done cycle
      MvSrc = 3'd3; MvDst = 3'd3; MvSwap = 1'b1; MvStart = 1'b1;
      step();
      MvStart = 1'b0;
      count_busy(n);
      check("same_busy_cycles", n, 3);
      check("same_done", Done_a, 1'b1);
      read_a(3'd3, v); check("same_r3", v, 16'hFFFF);
      MvSrc = 3'd3; MvDst = 3'd4; MvSwap = 1'b0; MvStart = 1'b1;
      step();
      MvStart = 1'b0;
      check("b2b_busy", Busy_a, 1'b1);
      count_busy(n);
      check("b2b_busy_cycles", n, 1);
      check("b2b_done", Done_a, 1'b1);
      read_a(3'd4, v); check("b2b_r4", v, 16'hFFFF);
      step();

      // Same-cycle forwarding: B forwards, A shows the old value until the edge
      OutSel_a = {3'd4, 3'd4};
      OutSel_b = {3'd4, 3'd4, 3'd4};
      RegSel = 8'hEF; FunSel = 3'b010; I = 16'hBEEF;
      #1;
      check("bypass_b", OutData_b, {3{16'hBEEF}});
      check("nobypass_a", OutData_a, {2{16'hFFFF}});
      step();
      RegSel = 8'hFF;
      #1;
      check("after_edge_a", OutData_a, {2{16'hBEEF}});

      // Swap aborted by reset during SW2
      MvSrc = 3'd2; MvDst = 3'd5; MvSwap = 1'b1; MvStart = 1'b1;
      step();
      MvStart = 1'b0;
      step();
      check("abort_busy_before", Busy_a, 1'b1);
      Reset = 1'b0;
      #1;
      check("abort_busy", Busy_a, 1'b0);
      check("abort_done", Done_a, 1'b0);
      read_a(3'd2, v); check("abort_r2", v, 16'h0000);
      read_a(3'd5, v); check("abort_r5", v, 16'h0000);
      read_a(3'd4, v); check("abort_r4", v, 16'h0000);
      step();
      Reset = 1'b1;
      done_seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         done_seen = done_seen | Done_a | Busy_a;
      end
      check("abort_no_done", done_seen, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
